// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with an OUT_DEPTH-entry result FIFO between decode and operand mux.
// Optional: define IMM_SHAMT_MASK_EN to emit a zero-extended shift amount for shift-immediate ops.
module imm_gen_pipe #(
    parameter int XLEN      = 64,
    parameter int TAG_W     = 64,
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_imm,
    output logic [2:0]                   out_fmt,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(OUT_DEPTH):0]   count
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [31:0] instr);
        fmt_t f;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: f = FMT_I;
            7'b0100011:                                     f = FMT_S;
            7'b1100011:                                     f = FMT_B;
            7'b0110111, 7'b0010111:                         f = FMT_U;
            7'b1101111:                                     f = FMT_J;
            default:                                        f = FMT_NONE;
        endcase
        return f;
    endfunction

    // Every format is first assembled as a signed 32-bit value, then sign-extended to XLEN.
    function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr);
        logic signed [31:0] imm32;
        imm32 = '0;
        case (decode_fmt(instr))
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
`ifdef IMM_SHAMT_MASK_EN
        if (instr[13:12] == 2'b01 && instr[6:0] == 7'b0010011)
            return XLEN'(instr[25:20]);
        if (instr[13:12] == 2'b01 && instr[6:0] == 7'b0011011)
            return XLEN'(instr[24:20]);
`endif
        return XLEN'(imm32);
    endfunction

    logic [XLEN-1:0]  mem_imm [OUT_DEPTH];
    logic [2:0]       mem_fmt [OUT_DEPTH];
    logic [TAG_W-1:0] mem_tag [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  imm_p0;
    logic [2:0]       fmt_p0;

    assign in_ready  = (count < CW'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign imm_p0    = decode_imm(in_instr);
    assign fmt_p0    = decode_fmt(in_instr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode to FIFO storage boundary: results are captured at acceptance.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= imm_p0;
            mem_fmt[wr_ptr] <= fmt_p0;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Storage is never cleared, so an empty FIFO forces the head outputs to zero.
    assign out_imm = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_fmt = out_valid ? mem_fmt[rd_ptr] : 3'd0;
    assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: expected results queued on acceptance, compared at the FIFO head.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [63:0] out_tag;
    logic [1:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(64), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_tag   (out_tag),
        .count     (count)
    );

    localparam int NV = 8;
    logic [31:0] v_instr [NV];
    logic [2:0]  v_fmt   [NV];
    logic [63:0] v_imm   [NV];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: drive after a falling edge, sample 1 ns later, advance to the next falling edge.
    task automatic step(input logic v, input int idx, input logic [63:0] t, input logic rdy,
                        output logic acc);
        exp_t e;
        in_valid  = v;
        in_instr  = v_instr[idx];
        in_tag    = t;
        out_ready = rdy;
        #1;
        check("count", 64'(count), 64'(sb.size()));
        check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_imm", out_imm, sb[0].imm);
            check("out_fmt", 64'(out_fmt), 64'(sb[0].fmt));
            check("out_tag", out_tag, sb[0].tag);
            if (rdy)
                void'(sb.pop_front());
        end
        acc = v && in_ready;
        if (acc) begin
            e.imm = v_imm[idx];
            e.fmt = v_fmt[idx];
            e.tag = t;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input int idx, input logic [63:0] t, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++)
            step(1'b1, idx, t, rdy, acc);
        if (!acc)
            check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && sb.size() != 0; k++)
            step(1'b0, 0, 64'd0, 1'b1, acc);
        check("drain_empty", 64'(sb.size()), 64'd0);
        step(1'b0, 0, 64'd0, 1'b1, acc);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_count"}, 64'(count), 64'd0);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_out_imm"}, out_imm, 64'd0);
        check({pfx, "_out_fmt"}, 64'(out_fmt), 64'd0);
        check({pfx, "_out_tag"}, out_tag, 64'd0);
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic acc;
        v_instr[0] = 32'hFFF00093; v_fmt[0] = 3'd1; v_imm[0] = 64'hFFFFFFFFFFFFFFFF;
        v_instr[1] = 32'hFE112E23; v_fmt[1] = 3'd2; v_imm[1] = 64'hFFFFFFFFFFFFFFFC;
        v_instr[2] = 32'h00000463; v_fmt[2] = 3'd3; v_imm[2] = 64'h0000000000000008;
        v_instr[3] = 32'h123450B7; v_fmt[3] = 3'd4; v_imm[3] = 64'h0000000012345000;
        v_instr[4] = 32'hFFDFF06F; v_fmt[4] = 3'd5; v_imm[4] = 64'hFFFFFFFFFFFFFFFC;
        v_instr[5] = 32'h0000000B; v_fmt[5] = 3'd0; v_imm[5] = 64'h0;
        v_instr[6] = 32'h40515093; v_fmt[6] = 3'd1;
`ifdef IMM_SHAMT_MASK_EN
        v_imm[6] = 64'h5;
`else
        v_imm[6] = 64'h405;
`endif
        v_instr[7] = 32'h00500093; v_fmt[7] = 3'd1; v_imm[7] = 64'h5;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        check_reset_state("por");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // All formats back to back with the consumer always ready.
        for (int i = 0; i < NV; i++)
            send(i, 64'hA000_0000_0000_0000 + 64'(i), 1'b1);
        drain();

        // Backpressure: two fill the FIFO, the third waits until count drops.
        send(0, 64'hB1, 1'b0);
        send(3, 64'hB2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4, 64'hB3, 1'b0, acc);
            check("held_when_full", 64'(acc), 64'd0);
        end
        step(1'b1, 4, 64'hB3, 1'b1, acc);
        check("refused_full_with_pop", 64'(acc), 64'd0);
        step(1'b1, 4, 64'hB3, 1'b1, acc);
        check("accepted_after_drop", 64'(acc), 64'd1);
        drain();

        // Sustained push and pop at occupancy one; pointers wrap several times.
        send(7, 64'hC0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, k % NV, 64'hC0 + 64'(k), 1'b1, acc);
            check("stream_accept", 64'(acc), 64'd1);
        end
        drain();

        // Asynchronous reset with two entries buffered.
        send(1, 64'hD1, 1'b0);
        send(2, 64'hD2, 1'b0);
        in_valid = 1'b0;
        #1;
        check("pre_reset_count", 64'(count), 64'd2);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_state("mid");
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(6, 64'hE1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It accepts 32-bit RISC-V instructions over a valid/ready handshake and classifies each one as I/S/B/U/J format. It sign-extends the immediate to XLEN bits and buffers results, with a pass-through tag, in an OUT_DEPTH-entry output FIFO. It sits between fetch/instruction register and the register-file/ALU operand mux, decoupling decode from downstream stalls.

Parameters:
XLEN, 64, width of generated immediate (32 or 64)
TAG_W, 64, width of sideband tag carried with each instruction (typically PC)
OUT_DEPTH, 2, output FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction presented
in_ready  out  1  block can accept instruction this cycle
in_instr  in  32  instruction word
in_tag  in  TAG_W  sideband tag, returned unchanged
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer takes head this cycle
out_imm  out  XLEN  sign-extended immediate at head
out_fmt  out  3  format at head: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
out_tag  out  TAG_W  tag at head
count  out  $clog2(OUT_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): count=0, out_valid=0, out_imm=0, out_fmt=0, out_tag=0, in_ready=1; read/write pointers=0; FIFO contents need not be cleared.
- Reset asserted mid-operation discards all buffered entries immediately; no partial handshake completes.
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < OUT_DEPTH). No combinational path from out_ready to in_ready. When full, push is refused even if pop occurs that cycle.
- out_valid = (count != 0); out_* driven from head entry (registered storage, no combinational path from in_* to out_*).
- Latency: pushed instruction visible at out_* the cycle after acceptance when FIFO was empty.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo OUT_DEPTH.
- out_imm/out_fmt/out_tag hold stable while out_valid=1 and out_ready=0.
- Format by opcode instr[6:0]:
  - I: 0010011, 0000011, 1100111, 0011011. imm = sext(instr[31:20]).
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), byte offset with LSB 0.
  - U: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}).
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: fmt=NONE, imm=0.
- Sign extension always from instr[31] to XLEN. For XLEN=32, U imm equals {instr[31:12], 12'b0} exactly.

Optional Feature:
Macro IMM_SHAMT_MASK_EN.
- Defined: for I-format opcodes 0010011 and 0011011 with funct3 = 001 or 101 (shifts), out_imm = zero-extended shamt, i.e. instr[25:20] for 0010011 and instr[24:20] for 0011011. funct7 bits are excluded, so SRAI yields a plain shift amount.
- Undefined: shifts are treated as ordinary I-format, imm = sext(instr[31:20]).

Test Plan:
- Reset: assert reset_n=0 mid-stream with count=2 -> count=0, out_valid=0, out_imm=0, in_ready=1 in the same cycle, before the next clock edge.
- Formats, out_ready=1, back-to-back pushes:
  - 0xFFF00093 -> fmt 1, imm 0xFFFFFFFFFFFFFFFF.
  - 0xFE112E23 -> fmt 2, imm 0xFFFFFFFFFFFFFFFC.
  - 0x00000463 -> fmt 3, imm 0x8.
  - 0x123450B7 -> fmt 4, imm 0x0000000012345000.
  - 0xFFDFF06F -> fmt 5, imm 0xFFFFFFFFFFFFFFFC.
  - Each result appears one cycle after acceptance, in order, tags intact.
- Backpressure: out_ready=0, push 3 instructions -> first 2 accepted, in_ready=0 after second, third held. Head stable. Releasing out_ready drains in order, and third is accepted the cycle after count drops.
- Simultaneous push/pop at count=1 -> count stays 1, pointers wrap correctly over 10 cycles, no loss or duplication (scoreboard).
- Unknown opcode 0x0000000B -> fmt 0, imm 0.
- Shift 0x40515093 (srai x1,x2,5): with IMM_SHAMT_MASK_EN imm=0x5; without it imm=0x405.
